word_serializer: RTL and testbench
==================================

// Module: word_serializer
// PURPOSE
//   Parallel-to-serial transmitter: accepts a WORD_WIDTH word over a valid/ready handshake
//   and shifts it out one bit per beat, LSB-first or MSB-first, selected per word.
//   Sits between word-level datapaths and bit-serial links. MSB-first mode emits the
//   bit-reversed order of LSB-first mode, so no separate bit-order stage is needed.
// PARAMETERS
//   WORD_WIDTH  8  width of parallel input word; legal range >= 2
// PORTS
//   clk        in   1           clock, all state on rising edge
//   rst        in   1           synchronous reset, active-high
//   in_data    in   WORD_WIDTH  parallel word, sampled on accept
//   in_msb     in   1           bit order for this word: 0 = LSB first, 1 = MSB first; sampled on accept
//   in_valid   in   1           upstream word valid
//   in_ready   out  1           block can accept a word this cycle
//   ser_out    out  1           current serial bit
//   ser_valid  out  1           ser_out holds a valid bit
//   ser_ready  in   1           downstream consumes the bit this cycle
//   ser_last   out  1           current bit is the final bit of the word
// BEHAVIOUR
//   - Accept = in_valid & in_ready. Beat = ser_valid & ser_ready.
//   - State: IDLE (no word held), SHIFT (word in flight). Registers: shreg[WORD_WIDTH],
//     order_q, cnt[$clog2(WORD_WIDTH)].
//   - Reset (rst high at edge): state=IDLE, shreg=0, order_q=0, cnt=0. While rst is high,
//     in_ready=0. After reset: ser_valid=0, ser_out=0, ser_last=0.
//   - in_ready = !rst & ((state==IDLE) | (beat & ser_last)). Combinational from ser_ready;
//     no combinational path from in_valid to any output.
//   - IDLE: on accept load shreg=in_data, order_q=in_msb, cnt=0, go SHIFT. No accept: stay.
//   - SHIFT: ser_valid=1; ser_out = order_q ? shreg[WORD_WIDTH-1] : shreg[0];
//     ser_last = (cnt==WORD_WIDTH-1).
//   - Beat, not last: shreg shifts toward the output end (right if LSB first, left if MSB
//     first), zero-fill; cnt+1.
//   - Beat on last bit: if accept in the same cycle, reload as in IDLE and stay in SHIFT,
//     giving back-to-back words with no bubble. Otherwise go to IDLE, cnt=0.
//   - No beat (ser_ready=0): shreg, cnt, order_q, ser_out, ser_last all hold; ser_valid
//     stays 1. Once asserted, ser_valid never drops until its bit is consumed.
//   - Latency: first bit has ser_valid=1 in the cycle after accept. Sustained throughput
//     is WORD_WIDTH beats per word.
//   - in_valid while in_ready=0: ignored. in_data and in_msb are not sampled.
//   - Reset mid-word: the in-flight word is discarded, with no further beats.
//     The next accepted word starts at bit 0.
//   - cnt never exceeds WORD_WIDTH-1. cnt wraps only via reload or return to IDLE.
// TESTING
//   1. W=8, in_msb=0, in_data=8'hC1, ser_ready=1 -> ser_out 1,0,0,0,0,0,1,1 on 8
//      consecutive cycles starting 1 cycle after accept; ser_last only on 8th; then IDLE.
//   2. W=8, in_msb=1, in_data=8'hC1 -> ser_out 1,1,0,0,0,0,0,1; ser_last on 8th beat.
//   3. 8'hC1 LSB-first, ser_ready low 3 cycles after bit 2 -> ser_valid=1, ser_out=0 held
//      for 3 cycles; remaining bits are 0,0,0,1,1 with none lost or duplicated.
//   4. in_valid held, words 8'hFF (LSB) then 8'h0F (MSB) -> 16 contiguous beats
//      1x8 then 0,0,0,0,1,1,1,1; in_ready=1 only in the cycle of beat 8.
//   5. Accept 8'hAA, rst high for 1 cycle after 3 beats -> ser_valid=0 and in_ready=0 during
//      reset; then in_ready=1; a new word 8'h01 LSB-first emits 1,0,0,0,0,0,0,0.
//   6. While SHIFT and not on last bit, pulse in_valid with 8'h55 -> in_ready=0, the current
//      word's bit stream is unchanged, and 8'h55 is never emitted.

Source files
------------

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: takes a word over valid/ready and shifts it out one bit per
// beat, LSB-first or MSB-first as chosen per word, with back-to-back reload on the last beat.
module word_serializer #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_msb,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  ser_last
);

  localparam int unsigned CntW = $clog2(WORD_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WORD_WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic                  order_q, order_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  beat, accept;

  // Outputs are gated by rst so the in-flight word produces no beat in the reset cycle.
  always_comb begin
    ser_valid = !rst && (state_q == StShift);
    ser_out   = ser_valid && (order_q ? shreg_q[WORD_WIDTH-1] : shreg_q[0]);
    ser_last  = ser_valid && (cnt_q == CntLast);
    beat      = ser_valid && ser_ready;
    in_ready  = !rst && ((state_q == StIdle) || (beat && ser_last));
    accept    = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    order_d = order_q;
    cnt_d   = cnt_q;
    if (accept) begin
      // Covers both the idle load and the same-cycle reload on the last beat.
      state_d = StShift;
      shreg_d = in_data;
      order_d = in_msb;
      cnt_d   = '0;
    end else if (beat) begin
      if (ser_last) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        shreg_d = order_q ? {shreg_q[WORD_WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WORD_WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      order_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      order_q <= order_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: table of single words plus hand-written stall,
// back-to-back, reset and ignored-input sequences. Outputs are sampled on the falling edge.
module tb_word_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_msb = 1'b0;
  logic       in_valid = 1'b0;
  logic       ser_ready = 1'b1;
  logic       in_ready, ser_out, ser_valid, ser_last;

  int errors = 0;
  int checks = 0;

  // exp[i] is the i-th bit expected on ser_out.
  typedef struct {
    logic       msb;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  word_serializer #(.WORD_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_msb   (in_msb),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .ser_last (ser_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_bit(input string tag, input int i, input logic b, input logic last);
    check($sformatf("%s valid[%0d]", tag, i), ser_valid, 1'b1);
    check($sformatf("%s out[%0d]", tag, i), ser_out, b);
    check($sformatf("%s last[%0d]", tag, i), ser_last, last);
  endtask

  // Called on a falling edge with the block idle; returns on a falling edge, idle again.
  task automatic send_and_stream(input string tag, input logic msb, input logic [7:0] data,
                                 input logic [7:0] exp);
    check({tag, " ready_idle"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = data;
    in_msb   = msb;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_bit(tag, i, exp[i], i == 7);
      check($sformatf("%s in_ready[%0d]", tag, i), in_ready, i == 7);
      @(negedge clk);
    end
    check({tag, " idle_after"}, ser_valid, 1'b0);
  endtask

  initial begin
    logic [7:0]  e;
    logic [15:0] s;

    vecs[0] = '{msb: 1'b0, data: 8'hC1, exp: 8'hC1};
    vecs[1] = '{msb: 1'b1, data: 8'hC1, exp: 8'h83};
    vecs[2] = '{msb: 1'b1, data: 8'h0F, exp: 8'hF0};
    vecs[3] = '{msb: 1'b0, data: 8'h12, exp: 8'h12};
    vecs[4] = '{msb: 1'b1, data: 8'h12, exp: 8'h48};
    vecs[5] = '{msb: 1'b1, data: 8'h80, exp: 8'h01};
    vecs[6] = '{msb: 1'b0, data: 8'h80, exp: 8'h80};

    // Reset state.
    @(negedge clk);
    check("rst in_ready", in_ready, 1'b0);
    check("rst ser_valid", ser_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst in_ready", in_ready, 1'b1);
    check("post_rst ser_valid", ser_valid, 1'b0);
    check("post_rst ser_out", ser_out, 1'b0);
    check("post_rst ser_last", ser_last, 1'b0);
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      send_and_stream($sformatf("vec%0d", v), vecs[v].msb, vecs[v].data, vecs[v].exp);
    end

    // Stall: three cycles with ser_ready low after bit 2 is consumed.
    e = 8'hC1;
    in_valid = 1'b1; in_data = 8'hC1; in_msb = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_bit("stall", i, e[i], 1'b0);
      @(negedge clk);
    end
    ser_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_bit("stall_hold", k, 1'b0, 1'b0);
      check($sformatf("stall_hold in_ready[%0d]", k), in_ready, 1'b0);
      @(negedge clk);
    end
    ser_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      check_bit("stall", i, e[i], i == 7);
      @(negedge clk);
    end
    check("stall idle_after", ser_valid, 1'b0);

    // Back-to-back: 8'hFF LSB then 8'h0F MSB with in_valid held.
    s = 16'hF0FF;
    in_valid = 1'b1; in_data = 8'hFF; in_msb = 1'b0;
    @(negedge clk);
    in_data = 8'h0F; in_msb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) in_valid = 1'b0;
      check_bit("b2b", i, s[i], (i % 8) == 7);
      if (i < 15) check($sformatf("b2b in_ready[%0d]", i), in_ready, i == 7);
      @(negedge clk);
    end
    check("b2b idle_after", ser_valid, 1'b0);

    // Reset mid-word after three beats of 8'hAA.
    e = 8'hAA;
    in_valid = 1'b1; in_data = 8'hAA; in_msb = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_bit("rstmid", i, e[i], 1'b0);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("rstmid ser_valid_in_rst", ser_valid, 1'b0);
    check("rstmid in_ready_in_rst", in_ready, 1'b0);
    check("rstmid ser_last_in_rst", ser_last, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid ser_valid_after", ser_valid, 1'b0);
    check("rstmid ser_out_after", ser_out, 1'b0);
    send_and_stream("rstmid_new", 1'b0, 8'h01, 8'h01);

    // in_valid pulse mid-word with 8'h55 must be ignored.
    e = 8'hC1;
    in_valid = 1'b1; in_data = 8'hC1; in_msb = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        in_valid = 1'b1; in_data = 8'h55; in_msb = 1'b1;
        #1;
        check("ignore in_ready", in_ready, 1'b0);
      end
      if (i == 4) in_valid = 1'b0;
      check_bit("ignore", i, e[i], i == 7);
      @(negedge clk);
    end
    check("ignore idle_after", ser_valid, 1'b0);
    @(negedge clk);
    check("ignore idle_after2", ser_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
